// File: rtl/l1_mem_arbiter_if.sv
// Bus bundle between the L1 caches, the line arbiter and the memory/MMU port.
// The slave modport is the arbiter's view; the master modport is the surrounding caches and memory.
interface l1_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_done;
  logic [LINE_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic              d_done;
  logic [LINE_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_done;
  logic [LINE_W-1:0] mem_rdata;

  logic              busy;
  logic              owner;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_done, mem_rdata,
    output i_done, i_rdata, d_done, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, busy, owner
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_done, mem_rdata,
    input  i_done, i_rdata, d_done, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, busy, owner
  );
endinterface

// File: rtl/l1_mem_arbiter.sv
// Line-wide memory port arbiter between I-L1 (read-only) and D-L1 (read/write-back).
// Optional macro L1_ARB_ROUND_ROBIN_EN swaps fixed D-over-I priority for round-robin.
module l1_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic            sys_clk,
  input  logic            rst,
  l1_mem_arbiter_if.slave bus
);

  localparam int OFF_W = $clog2(LINE_W / 8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    line_align = {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  endfunction

  state_t            state_r, state_s;
  logic              mem_req_r, mem_req_s;
  logic              mem_we_r, mem_we_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic [LINE_W-1:0] mem_wdata_r, mem_wdata_s;
  logic              i_done_r, i_done_s;
  logic              d_done_r, d_done_s;
  logic [LINE_W-1:0] i_rdata_r, i_rdata_s;
  logic [LINE_W-1:0] d_rdata_r, d_rdata_s;
  logic              busy_r, busy_s;
  logic              owner_r, owner_s;
  logic              grant_d_s;

`ifdef L1_ARB_ROUND_ROBIN_EN
  logic              prefer_d_r, prefer_d_s;

  // Round-robin winner selection; a lone request always wins.
  always_comb begin
    grant_d_s = bus.d_req && (!bus.i_req || prefer_d_r);
  end
`else
  // Fixed priority: D-L1 wins whenever it is requesting.
  always_comb begin
    grant_d_s = bus.d_req;
  end
`endif

  // Next-state and next-output computation for the transaction FSM.
  always_comb begin
    state_s     = state_r;
    mem_req_s   = mem_req_r;
    mem_we_s    = mem_we_r;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    i_done_s    = 1'b0;
    d_done_s    = 1'b0;
    i_rdata_s   = i_rdata_r;
    d_rdata_s   = d_rdata_r;
    busy_s      = busy_r;
    owner_s     = owner_r;
`ifdef L1_ARB_ROUND_ROBIN_EN
    prefer_d_s  = prefer_d_r;
`endif
    case (state_r)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          state_s   = BUSY;
          busy_s    = 1'b1;
          mem_req_s = 1'b1;
          owner_s   = grant_d_s;
`ifdef L1_ARB_ROUND_ROBIN_EN
          prefer_d_s = !grant_d_s;
`endif
          if (grant_d_s) begin
            mem_we_s    = bus.d_we;
            mem_addr_s  = line_align(bus.d_addr);
            mem_wdata_s = bus.d_wdata;
          end else begin
            mem_we_s    = 1'b0;
            mem_addr_s  = line_align(bus.i_addr);
            mem_wdata_s = {LINE_W{1'b0}};
          end
        end else begin
          state_s = IDLE;
          busy_s  = 1'b0;
        end
      end
      BUSY: begin
        if (bus.mem_done) begin
          state_s   = DONE;
          mem_req_s = 1'b0;
          // Write-backs never disturb the returned-line registers.
          if (!mem_we_r && owner_r) begin
            d_rdata_s = bus.mem_rdata;
          end else if (!mem_we_r) begin
            i_rdata_s = bus.mem_rdata;
          end else begin
            d_rdata_s = d_rdata_r;
          end
          if (owner_r) begin
            d_done_s = 1'b1;
          end else begin
            i_done_s = 1'b1;
          end
        end else begin
          state_s = BUSY;
        end
      end
      DONE: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s   = IDLE;
        busy_s    = 1'b0;
        mem_req_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction without a done pulse.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {LINE_W{1'b0}};
      i_done_r    <= 1'b0;
      d_done_r    <= 1'b0;
      i_rdata_r   <= {LINE_W{1'b0}};
      d_rdata_r   <= {LINE_W{1'b0}};
      busy_r      <= 1'b0;
      owner_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      mem_req_r   <= mem_req_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      i_done_r    <= i_done_s;
      d_done_r    <= d_done_s;
      i_rdata_r   <= i_rdata_s;
      d_rdata_r   <= d_rdata_s;
      busy_r      <= busy_s;
      owner_r     <= owner_s;
    end
  end

`ifdef L1_ARB_ROUND_ROBIN_EN
  // Round-robin pointer; starts out favouring I-L1.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      prefer_d_r <= 1'b0;
    end else begin
      prefer_d_r <= prefer_d_s;
    end
  end
`endif

  assign bus.mem_req   = mem_req_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.i_done    = i_done_r;
  assign bus.d_done    = d_done_r;
  assign bus.i_rdata   = i_rdata_r;
  assign bus.d_rdata   = d_rdata_r;
  assign bus.busy      = busy_r;
  assign bus.owner     = owner_r;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Directed self-checking bench for l1_mem_arbiter; inputs driven and outputs sampled on the falling edge.
module tb_l1_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic sys_clk;
  logic rst;
  int   n_cmp;
  int   n_mis;
  logic [LINE_W-1:0] r_a5;
  logic [LINE_W-1:0] r_d1;
  logic [LINE_W-1:0] r_i2;
  logic [LINE_W-1:0] r_z;
  logic [LINE_W-1:0] r_n;
  logic [LINE_W-1:0] rv;
  logic              exp_own;
  logic              pend_i;
  logic              pend_d;
  logic              rr_en;

  l1_mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  l1_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check_value(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_mis = n_mis + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge sys_clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_mis = 0;
`ifdef L1_ARB_ROUND_ROBIN_EN
    rr_en = 1'b1;
`else
    rr_en = 1'b0;
`endif
    r_a5 = {32{8'hA5}};
    r_d1 = {8{32'hD1D1_0001}};
    r_i2 = {8{32'h1E1E_0002}};
    r_z  = {8{32'h5A5A_0003}};
    r_n  = {8{32'hBADB_AD00}};
    rst  = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 256'h0;
    bus.mem_done = 1'b0; bus.mem_rdata = 256'h0;

    // Reset state
    tick; tick;
    check_value("rst_mem_req", 256'(bus.mem_req), 256'h0);
    check_value("rst_busy", 256'(bus.busy), 256'h0);
    check_value("rst_owner", 256'(bus.owner), 256'h0);
    check_value("rst_i_rdata", bus.i_rdata, 256'h0);
    check_value("rst_d_rdata", bus.d_rdata, 256'h0);
    check_value("rst_i_done", 256'(bus.i_done), 256'h0);
    rst = 1'b0;

    // I read alone, memory answers in the third BUSY cycle
    tick;
    bus.i_addr = 32'h0000_1004; bus.i_req = 1'b1;
    tick;
    check_value("t1_mem_req", 256'(bus.mem_req), 256'h1);
    check_value("t1_mem_addr", 256'(bus.mem_addr), 256'h1000);
    check_value("t1_mem_we", 256'(bus.mem_we), 256'h0);
    check_value("t1_mem_wdata", bus.mem_wdata, 256'h0);
    check_value("t1_owner", 256'(bus.owner), 256'h0);
    check_value("t1_busy", 256'(bus.busy), 256'h1);
    tick; tick;
    check_value("t1_i_done_early", 256'(bus.i_done), 256'h0);
    check_value("t1_addr_held", 256'(bus.mem_addr), 256'h1000);
    bus.mem_done = 1'b1; bus.mem_rdata = r_a5;
    tick;
    check_value("t1_i_done", 256'(bus.i_done), 256'h1);
    check_value("t1_d_done", 256'(bus.d_done), 256'h0);
    check_value("t1_i_rdata", bus.i_rdata, r_a5);
    check_value("t1_mem_req_drop", 256'(bus.mem_req), 256'h0);
    bus.mem_done = 1'b0; bus.mem_rdata = 256'h0; bus.i_req = 1'b0;
    tick;
    check_value("t1_i_done_once", 256'(bus.i_done), 256'h0);
    check_value("t1_busy_idle", 256'(bus.busy), 256'h0);

    // Simultaneous reads: D served first, then I
    bus.d_we = 1'b0; bus.d_addr = 32'h0000_3040; bus.i_addr = 32'h0000_4000;
    bus.d_req = 1'b1; bus.i_req = 1'b1;
    tick;
    check_value("t3_owner_d", 256'(bus.owner), 256'h1);
    check_value("t3_mem_addr_d", 256'(bus.mem_addr), 256'h3040);
    bus.mem_done = 1'b1; bus.mem_rdata = r_d1;
    tick;
    check_value("t3_d_done", 256'(bus.d_done), 256'h1);
    check_value("t3_i_done_wait", 256'(bus.i_done), 256'h0);
    check_value("t3_d_rdata", bus.d_rdata, r_d1);
    bus.mem_done = 1'b0; bus.d_req = 1'b0;
    tick;
    tick;
    check_value("t3_owner_i", 256'(bus.owner), 256'h0);
    check_value("t3_mem_addr_i", 256'(bus.mem_addr), 256'h4000);
    bus.mem_done = 1'b1; bus.mem_rdata = r_i2;
    tick;
    check_value("t3_i_done", 256'(bus.i_done), 256'h1);
    check_value("t3_i_rdata", bus.i_rdata, r_i2);
    bus.mem_done = 1'b0; bus.i_req = 1'b0;
    tick;

    // D write-back leaves d_rdata alone
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_2020; bus.d_wdata = 256'h1234;
    tick;
    check_value("t2_mem_we", 256'(bus.mem_we), 256'h1);
    check_value("t2_mem_addr", 256'(bus.mem_addr), 256'h2020);
    check_value("t2_mem_wdata", bus.mem_wdata, 256'h1234);
    check_value("t2_owner", 256'(bus.owner), 256'h1);
    bus.mem_done = 1'b1; bus.mem_rdata = r_n;
    tick;
    check_value("t2_d_done", 256'(bus.d_done), 256'h1);
    check_value("t2_d_rdata_kept", bus.d_rdata, r_d1);
    bus.mem_done = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    tick;
    check_value("t2_d_done_once", 256'(bus.d_done), 256'h0);

    // Zero-wait memory, plus a stray mem_done in IDLE
    bus.i_addr = 32'h0000_501F; bus.i_req = 1'b1;
    tick;
    check_value("t6_mem_req", 256'(bus.mem_req), 256'h1);
    check_value("t6_mem_addr", 256'(bus.mem_addr), 256'h5000);
    bus.mem_done = 1'b1; bus.mem_rdata = r_z;
    tick;
    check_value("t6_i_done", 256'(bus.i_done), 256'h1);
    check_value("t6_mem_req_drop", 256'(bus.mem_req), 256'h0);
    check_value("t6_i_rdata", bus.i_rdata, r_z);
    bus.mem_done = 1'b0; bus.i_req = 1'b0;
    tick;
    check_value("t6_no_rereq", 256'(bus.mem_req), 256'h0);
    bus.mem_done = 1'b1; bus.mem_rdata = r_n;
    tick;
    check_value("t6_stray_busy", 256'(bus.busy), 256'h0);
    check_value("t6_stray_rdata", bus.i_rdata, r_z);
    check_value("t6_stray_done", 256'(bus.i_done), 256'h0);
    bus.mem_done = 1'b0;

    // Reset mid-BUSY aborts silently
    bus.i_addr = 32'h0000_6000; bus.i_req = 1'b1;
    tick;
    check_value("t5_mem_req_pre", 256'(bus.mem_req), 256'h1);
    #2 rst = 1'b1;
    #1;
    check_value("t5_mem_req_async", 256'(bus.mem_req), 256'h0);
    check_value("t5_busy_async", 256'(bus.busy), 256'h0);
    check_value("t5_i_done_async", 256'(bus.i_done), 256'h0);
    check_value("t5_d_done_async", 256'(bus.d_done), 256'h0);
    check_value("t5_i_rdata_clr", bus.i_rdata, 256'h0);
    bus.i_req = 1'b0;
    tick; tick;
    rst = 1'b0;
    tick;
    check_value("t5_no_done", 256'(bus.i_done), 256'h0);
    bus.i_req = 1'b1;
    tick;
    check_value("t5_mem_req_new", 256'(bus.mem_req), 256'h1);
    bus.mem_done = 1'b1; bus.mem_rdata = r_a5;
    tick;
    check_value("t5_i_done_new", 256'(bus.i_done), 256'h1);
    check_value("t5_i_rdata_new", bus.i_rdata, r_a5);
    bus.mem_done = 1'b0; bus.i_req = 1'b0;
    tick;

    // Both requesters reassert after each done; fresh reset clears the pointer
    rst = 1'b1;
    tick;
    rst = 1'b0;
    bus.d_we = 1'b0; bus.i_addr = 32'h0000_7000; bus.d_addr = 32'h0000_8000;
    tick;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    pend_i = 1'b0; pend_d = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_own = rr_en ? (k % 2 == 1) : (k % 2 == 0);
      for (int w = 0; w < 6 && !bus.mem_req; w++) tick;
      check_value("t4_mem_req", 256'(bus.mem_req), 256'h1);
      check_value("t4_owner", 256'(bus.owner), 256'(exp_own));
      if (pend_i) bus.i_req = 1'b1;
      if (pend_d) bus.d_req = 1'b1;
      pend_i = 1'b0; pend_d = 1'b0;
      rv = {8{32'hC0DE_0000 + 32'(k)}};
      bus.mem_done = 1'b1; bus.mem_rdata = rv;
      tick;
      check_value("t4_i_done", 256'(bus.i_done), 256'(!exp_own));
      check_value("t4_d_done", 256'(bus.d_done), 256'(exp_own));
      check_value("t4_rdata", exp_own ? bus.d_rdata : bus.i_rdata, rv);
      bus.mem_done = 1'b0;
      if (k == 3) begin
        bus.i_req = 1'b0; bus.d_req = 1'b0;
      end else if (exp_own) begin
        bus.d_req = 1'b0; pend_d = 1'b1;
      end else begin
        bus.i_req = 1'b0; pend_i = 1'b1;
      end
      tick;
    end

    // Simultaneous requests after the last grant: round-robin picks the other side
    tick;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    tick;
    check_value("t4_final_owner", 256'(bus.owner), rr_en ? 256'h0 : 256'h1);
    bus.mem_done = 1'b1; bus.mem_rdata = r_i2;
    tick;
    check_value("t4_final_done", 256'(rr_en ? bus.i_done : bus.d_done), 256'h1);
    bus.mem_done = 1'b0; bus.i_req = 1'b0; bus.d_req = 1'b0;
    tick; tick;
    check_value("end_busy", 256'(bus.busy), 256'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/l1_mem_arbiter.md
Name: l1_mem_arbiter

Overview:
- Shares the single line-wide memory/MMU port between the L1 instruction cache (read-only) and the L1 data cache (read and write-back).
- Sits between both L1 caches and the memory/MMU.
- Grants one whole line transaction at a time and holds the grant until the memory completes.
- Returns a one-cycle done pulse and the line data to the owning cache.

Parameters:
- ADDR_W, 32, byte address width
- LINE_W, 256, cache line width in bits; the number of offset bits is log2(LINE_W/8), which is 5 at the default

Ports:
- sys_clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  I-L1 line read request; level-held until i_done
- i_addr  in  ADDR_W  I-L1 line address
- i_done  out  1  one-cycle pulse: I transaction complete, i_rdata valid
- i_rdata  out  LINE_W  line read for I-L1
- d_req  in  1  D-L1 request; level-held until d_done
- d_we  in  1  1 = line write, 0 = line read
- d_addr  in  ADDR_W  D-L1 line address
- d_wdata  in  LINE_W  line to write
- d_done  out  1  one-cycle pulse: D transaction complete
- d_rdata  out  LINE_W  line read for D-L1
- mem_req  out  1  request to memory; held until mem_done
- mem_we  out  1  write strobe to memory
- mem_addr  out  ADDR_W  line-aligned address
- mem_wdata  out  LINE_W  write line
- mem_done  in  1  one-cycle completion from memory
- mem_rdata  in  LINE_W  read line; valid while mem_done=1
- busy  out  1  1 in any state other than IDLE
- owner  out  1  0 = I-L1, 1 = D-L1; owner of the current or last grant

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE; all outputs 0, including the rdata registers; owner=0.
  - The round-robin pointer favours I next.
  - Reset asserted mid-transaction aborts it silently: no done pulse is produced and mem_req drops immediately.
- All outputs are registered.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If any request is high, choose a winner (see priority rule).
  - Latch the winner's address, write flag and write data; set owner; go to BUSY with mem_req=1 on the next cycle.
  - With no request, remain in IDLE.
- BUSY:
  - mem_req=1; mem_addr, mem_we and mem_wdata are held constant.
  - Address alignment: mem_addr = latched address with the low log2(LINE_W/8) bits forced to 0.
  - For I transactions, mem_we=0 and mem_wdata=0.
  - On mem_done=1:
    - Reads capture mem_rdata into the owner's rdata register.
    - Writes leave the rdata registers unchanged.
    - mem_req drops on the next cycle; go to DONE.
- DONE:
  - The owner's done output is 1 for exactly one cycle; the other requester's done output stays 0.
  - Go to IDLE.
  - rdata holds its value until that requester's next read completes.
- Requester contract:
  - req, addr, we and wdata stay stable from req rising until done is seen.
  - req must be 0 in the cycle after the done pulse, so the completed request is not re-granted.
- Latency:
  - Zero-wait memory: req high in cycle 0, mem_req in cycle 1, mem_done in cycle 1, done in cycle 2.
  - General case: done arrives 1 cycle after mem_done.
- Priority (default, fixed): if both requests are high in IDLE, D wins; I waits while D is busy.
- Requests arriving while BUSY or DONE are not sampled until IDLE.
- mem_done while IDLE or DONE is ignored.
- No request queueing: at most one outstanding memory transaction.

Optional Feature:
- Macro: L1_ARB_ROUND_ROBIN_EN.
- When defined:
  - Simultaneous requests in IDLE are granted to the requester not granted last.
  - The pointer updates at each grant; reset pointer = I.
  - A lone request is always granted.
- When undefined: fixed D-over-I priority as above, with no pointer register.

Test Plan:
1. I read alone: i_req=1, i_addr=0x00001004; memory returns mem_done with mem_rdata=0xA5..A5 after 3 cycles.
   -> mem_addr=0x00001000, mem_we=0; i_done pulses once, 1 cycle after mem_done; i_rdata=0xA5..A5; d_done stays 0.
2. D write: d_req=1, d_we=1, d_addr=0x00002020, d_wdata=0x1234.
   -> mem_we=1, mem_addr=0x00002020, mem_wdata=0x1234; d_done pulses once; d_rdata is unchanged.
3. Simultaneous I and D read requests, fixed priority.
   -> D is served first (owner=1), then I (owner=0); two done pulses, in the order d_done then i_done.
4. With L1_ARB_ROUND_ROBIN_EN defined: both requesters reassert immediately after each done, for 4 transactions.
   -> grant order is I, D, I, D.
5. Reset mid-BUSY: rst=1 while mem_req=1.
   -> mem_req, busy and both done outputs go to 0 asynchronously; after release, a new i_req completes normally.
6. Zero-wait memory: mem_done in the same cycle mem_req rises.
   -> done arrives 2 cycles after req; mem_req drops the cycle after mem_done, and is not re-raised while req is dropped after done.
